multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Main control FSM for the multicycle RV32I core. Sequences the shared datapath (PC, IR, register file, single ALU, unified memory, immediate extender) across 3–5 cycles per instruction.
- Emits all datapath select and enable strobes, including the `ImmSrc` code consumed by `extend`.
- Moore-style state outputs, plus combinational ALU decode and branch-taken logic.
- Supported instructions: lw, sw, R-type ALU, I-type ALU, beq, jal, lui.

Parameters:
- `STATE_W`, 4, width of the state register and debug port.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `op` in 7: `instr[6:0]` from the IR.
- `funct3` in 3: `instr[14:12]`.
- `funct7b5` in 1: `instr[30]`.
- `Zero` in 1: ALU zero flag.
- `PCWrite` out 1: PC register enable.
- `AdrSrc` out 1: memory address select. 0 = PC, 1 = Result.
- `MemWrite` out 1: memory write enable.
- `IRWrite` out 1: IR and OldPC load enable.
- `ResultSrc` out 2: 00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt.
- `ALUSrcA` out 2: 00 PC, 01 OldPC, 10 A (rs1).
- `ALUSrcB` out 2: 00 B (rs2), 01 ImmExt, 10 constant 4.
- `ALUControl` out 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `RegWrite` out 1: register-file write enable.
- `ImmSrc` out 3: 000 I, 001 S, 010 B, 011 J, 100 U.
- `instr_done` out 1: one-cycle pulse in the final state of each instruction.
- `illegal_op` out 1: one-cycle pulse in DECODE when `op` is unsupported.
- `state_dbg` out `STATE_W`: current state code.

Behaviour:
- Reset: asynchronous, active-low. Takes effect immediately; the state goes to FETCH regardless of the current state, including mid-instruction.
- While `reset_n`=0, all enables (`PCWrite`, `MemWrite`, `IRWrite`, `RegWrite`) and both pulses are forced to 0. Select outputs hold the FETCH values.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BEQ 9, JAL 10, LUI 11. Codes 12–15 are unreachable; if entered, next state is FETCH with all enables 0.
- Transitions:
  - FETCH → DECODE.
  - DECODE on `op`: lw/sw (0000011/0100011) → MEMADR; R (0110011) → EXECR; I (0010011) → EXECI; beq (1100011) → BEQ; jal (1101111) → JAL; lui (0110111) → LUI; any other → FETCH with `illegal_op`=1.
  - MEMADR → MEMREAD if lw, else → MEMWRITE.
  - MEMREAD → MEMWB.
  - EXECR, EXECI, JAL → ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BEQ, LUI → FETCH.
- Per-state outputs (unlisted enables are 0; unlisted selects are 00):
  - FETCH: `IRWrite`=1, ALUSrcA 00, ALUSrcB 10, ALUOp add, ResultSrc 10, PCUpdate=1.
  - DECODE: ALUSrcA 01, ALUSrcB 01, ALUOp add (branch target into ALUOut).
  - MEMADR: ALUSrcA 10, ALUSrcB 01, add.
  - MEMREAD: AdrSrc 1, ResultSrc 00.
  - MEMWB: ResultSrc 01, `RegWrite`=1.
  - MEMWRITE: AdrSrc 1, ResultSrc 00, `MemWrite`=1.
  - EXECR: ALUSrcA 10, ALUSrcB 00, ALUOp func.
  - EXECI: ALUSrcA 10, ALUSrcB 01, ALUOp func.
  - ALUWB: ResultSrc 00, `RegWrite`=1.
  - BEQ: ALUSrcA 10, ALUSrcB 00, ALUOp sub, ResultSrc 00, Branch=1.
  - JAL: ALUSrcA 01, ALUSrcB 10, add, ResultSrc 00, PCUpdate=1.
  - LUI: ResultSrc 11, `RegWrite`=1.
- `PCWrite` = PCUpdate | (Branch & `Zero`). Combinational and same-cycle; `Zero` is sampled in BEQ only.
- `ALUControl` (combinational):
  - ALUOp add → 000; ALUOp sub → 001.
  - ALUOp func, by `funct3`:
    - 000 → 001 if (`funct7b5` & `op[5]`), else 000.
    - 010 → 101.
    - 110 → 011.
    - 111 → 010.
    - any other → 000.
- `ImmSrc` is combinational from `op`, valid in every state: lw/I 000, sw 001, beq 010, jal 011, lui 100, others 000.
- `instr_done`=1 in MEMWB, MEMWRITE, ALUWB, BEQ and LUI.
- Latency, FETCH through last state inclusive: lw 5, sw 4, R 4, I 4, jal 4, beq 3, lui 3, illegal 2.

Test Plan:
1. Assert `reset_n`=0 mid-MEMREAD → `state_dbg` goes to 0 within the same cycle with no clock edge; `MemWrite`=`RegWrite`=`PCWrite`=0. Release → FETCH with `IRWrite`=1.
2. Hold `op`=0000011 → states 0,1,2,3,4. MEMWB shows ResultSrc 01, `RegWrite`=1, `instr_done`=1. `ImmSrc`=000 throughout.
3. Hold `op`=0110011, `funct3`=000, `funct7b5`=1 → EXECR shows `ALUControl`=001. Repeat with `op`=0010011, `funct7b5`=1 → EXECI shows 000 (addi, not sub).
4. Hold `op`=1100011 → BEQ state 9 with `ImmSrc`=010. With `Zero`=1, `PCWrite`=1; with `Zero`=0, `PCWrite`=0. Next state is FETCH after 3 cycles.
5. Hold `op`=0110111 → states 0,1,11. LUI shows ResultSrc 11, `RegWrite`=1, `ImmSrc`=100. Hold `op`=1101111 → JAL shows `PCWrite`=1 and `ImmSrc`=011, then ALUWB.
6. Hold `op`=1111111 → DECODE pulses `illegal_op`=1 for exactly one cycle with no write enables, then returns to FETCH.

Source files
------------

// File: rtl/multicycle_controller.sv
// Purpose: main control FSM for the multicycle RV32I core; drives every datapath select/enable.
// Latency: 3-5 cycles per instruction (lw 5; sw/R/I/jal 4; beq/lui 3; illegal op 2).
// Backpressure: none; the FSM free-runs one state per clock with no stall input.
module multicycle_controller #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [6:0]         op,
   input  logic [2:0]         funct3,
   input  logic               funct7b5,
   input  logic               Zero,
   output logic               PCWrite,
   output logic               AdrSrc,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic [1:0]         ResultSrc,
   output logic [1:0]         ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [2:0]         ALUControl,
   output logic               RegWrite,
   output logic [2:0]         ImmSrc,
   output logic               instr_done,
   output logic               illegal_op,
   output logic [STATE_W-1:0] state_dbg
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_LUI      = 4'd11
   } state_t;

   typedef enum logic [1:0] {
      ALU_ADD  = 2'd0,
      ALU_SUB  = 2'd1,
      ALU_FUNC = 2'd2
   } aluop_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_LUI = 7'b0110111;

   state_t state, next;
   aluop_t aluop;
   logic   pcupdate, branch, memwrite_s, irwrite_s, regwrite_s, done_s, illegal_s;

   // State register; reset lands in FETCH immediately, even mid-instruction.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_FETCH;
      else          state <= next;
   end

   // Next-state and Moore outputs per state; unreachable codes fall back to FETCH with enables low.
   always_comb begin
      next       = S_FETCH;
      pcupdate   = 1'b0;
      branch     = 1'b0;
      AdrSrc     = 1'b0;
      memwrite_s = 1'b0;
      irwrite_s  = 1'b0;
      regwrite_s = 1'b0;
      done_s     = 1'b0;
      illegal_s  = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      aluop      = ALU_ADD;
      case (state)
         S_FETCH: begin
            next      = S_DECODE;
            irwrite_s = 1'b1;
            pcupdate  = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         S_DECODE: begin
            // Branch target PC+imm is computed here so BEQ can compare rs1/rs2 next cycle.
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            case (op)
               OP_LW, OP_SW: next = S_MEMADR;
               OP_R:         next = S_EXECR;
               OP_I:         next = S_EXECI;
               OP_BEQ:       next = S_BEQ;
               OP_JAL:       next = S_JAL;
               OP_LUI:       next = S_LUI;
               default: begin
                  next      = S_FETCH;
                  illegal_s = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            next    = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         S_MEMREAD: begin
            next   = S_MEMWB;
            AdrSrc = 1'b1;
         end
         S_MEMWB: begin
            ResultSrc  = 2'b01;
            regwrite_s = 1'b1;
            done_s     = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc     = 1'b1;
            memwrite_s = 1'b1;
            done_s     = 1'b1;
         end
         S_EXECR: begin
            next    = S_ALUWB;
            ALUSrcA = 2'b10;
            aluop   = ALU_FUNC;
         end
         S_EXECI: begin
            next    = S_ALUWB;
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            aluop   = ALU_FUNC;
         end
         S_ALUWB: begin
            regwrite_s = 1'b1;
            done_s     = 1'b1;
         end
         S_BEQ: begin
            ALUSrcA = 2'b10;
            aluop   = ALU_SUB;
            branch  = 1'b1;
            done_s  = 1'b1;
         end
         S_JAL: begin
            next     = S_ALUWB;
            ALUSrcA  = 2'b01;
            ALUSrcB  = 2'b10;
            pcupdate = 1'b1;
         end
         S_LUI: begin
            ResultSrc  = 2'b11;
            regwrite_s = 1'b1;
            done_s     = 1'b1;
         end
         default: next = S_FETCH;
      endcase
   end

   // ALU operation decode; sub only for R-type funct3=000 with funct7b5 set (addi ignores bit 30).
   always_comb begin
      ALUControl = 3'b000;
      case (aluop)
         ALU_SUB: ALUControl = 3'b001;
         ALU_FUNC: begin
            case (funct3)
               3'b000:  ALUControl = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
               3'b010:  ALUControl = 3'b101;
               3'b110:  ALUControl = 3'b011;
               3'b111:  ALUControl = 3'b010;
               default: ALUControl = 3'b000;
            endcase
         end
         default: ALUControl = 3'b000;
      endcase
   end

   // Immediate format follows the opcode in every state so extend is always ready.
   always_comb begin
      case (op)
         OP_SW:   ImmSrc = 3'b001;
         OP_BEQ:  ImmSrc = 3'b010;
         OP_JAL:  ImmSrc = 3'b011;
         OP_LUI:  ImmSrc = 3'b100;
         default: ImmSrc = 3'b000;
      endcase
   end

   // Enables and pulses are held low while reset is asserted, independent of the clock.
   assign PCWrite    = reset_n & (pcupdate | (branch & Zero));
   assign MemWrite   = reset_n & memwrite_s;
   assign IRWrite    = reset_n & irwrite_s;
   assign RegWrite   = reset_n & regwrite_s;
   assign instr_done = reset_n & done_s;
   assign illegal_op = reset_n & illegal_s;
   assign state_dbg  = STATE_W'(state);

endmodule
